// File: rtl/seq_ctx_sched.sv
// Round-robin scheduler sharing one 2-bit sequence detector among NCH channels.
// Each channel's detector state lives in a context register file and is stepped only when granted.
module seq_ctx_sched #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   c_in,
  input  logic [NCH-1:0]   ctx_clr,
  output logic [NCH-1:0]   gnt,
  output logic             out_valid,
  output logic [CW-1:0]    out_ch,
  output logic             out_y,
  output logic [2*NCH-1:0] dbg_ctx
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b11,
    S3 = 2'b10
  } det_state_e;

  det_state_e        ctx_q [NCH];
  logic [CW-1:0]     last_q;
  logic              out_valid_q;
  logic [CW-1:0]     out_ch_q;
  logic              out_y_q;

  logic              found;
  logic [CW-1:0]     gnt_idx;
  logic              cur_c;
  det_state_e        cur_s;
  det_state_e        nxt_s;
  logic              y_d;

  // Search starts just after the last granted channel, wrapping modulo NCH.
  always_comb begin
    int idx;
    logic [CW-1:0] idx_c;
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(last_q) + k) % NCH;
      idx_c = CW'(idx);
      if (!found && req[idx_c]) begin
        found   = 1'b1;
        gnt_idx = idx_c;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    cur_s = ctx_q[gnt_idx];
    cur_c = c_in[gnt_idx];
    nxt_s = S0;
    unique case (cur_s)
      S0: nxt_s = cur_c ? S1 : S0;
      S1: nxt_s = cur_c ? S1 : S2;
      S2: nxt_s = cur_c ? S3 : S2;
      S3: nxt_s = cur_c ? S3 : S0;
      default: nxt_s = S0;
    endcase
    y_d = (cur_s == S2) | ((cur_s == S3) & cur_c);
  end

  // A clear on the granted channel overrides the write-back; the output still uses the old state.
  for (genvar i = 0; i < NCH; i++) begin : g_ctx
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctx_q[i] <= S0;
      end else if (ctx_clr[i]) begin
        ctx_q[i] <= S0;
      end else if (gnt[i]) begin
        ctx_q[i] <= nxt_s;
      end
    end
    assign dbg_ctx[2*i +: 2] = ctx_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= CW'(NCH - 1);
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_y_q     <= 1'b0;
    end else begin
      out_valid_q <= found;
      if (found) begin
        last_q   <= gnt_idx;
        out_ch_q <= gnt_idx;
        out_y_q  <= y_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_seq_ctx_sched.sv
// Directed and randomized bench for seq_ctx_sched against a behavioural scheduler/detector model.
module tb_seq_ctx_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   c_in;
  logic [NCH-1:0]   ctx_clr;
  logic [NCH-1:0]   gnt;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic             out_y;
  logic [2*NCH-1:0] dbg_ctx;

  seq_ctx_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .c_in(c_in), .ctx_clr(ctx_clr),
    .gnt(gnt), .out_valid(out_valid), .out_ch(out_ch), .out_y(out_y),
    .dbg_ctx(dbg_ctx)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: detector states as S-numbers 0..3, arbiter pointer as channel number
  int m_ctx [NCH];
  int m_last;
  int m_ov, m_ch, m_y;
  int wait_cnt [NCH];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int det_next(input int s, input bit c);
    case (s)
      0: return c ? 1 : 0;
      1: return c ? 1 : 2;
      2: return c ? 3 : 2;
      default: return c ? 3 : 0;
    endcase
  endfunction

  function automatic int det_y(input int s, input bit c);
    return ((s == 2) || (s == 3 && c)) ? 1 : 0;
  endfunction

  function automatic logic [2*NCH-1:0] exp_dbg();
    logic [1:0] enc [4];
    logic [2*NCH-1:0] v;
    enc[0] = 2'b00; enc[1] = 2'b01; enc[2] = 2'b11; enc[3] = 2'b10;
    v = '0;
    for (int i = 0; i < NCH; i++) v[2*i +: 2] = enc[m_ctx[i]];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctx[i] = 0;
      wait_cnt[i] = 0;
    end
    m_last = NCH - 1;
    m_ov = 0; m_ch = 0; m_y = 0;
  endtask

  // Driver: called at posedge+1, drives one cycle and checks grant then registered results.
  task automatic do_cycle(input logic [NCH-1:0] r, input logic [NCH-1:0] c, input logic [NCH-1:0] cl);
    int g;
    int nxt;
    logic [NCH-1:0] eg;
    req = r; c_in = c; ctx_clr = cl;
    #2;
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (m_last + k) % NCH;
      if (g < 0 && r[idx]) g = idx;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    for (int i = 0; i < NCH; i++) begin
      if (r[i]) begin
        wait_cnt[i] = gnt[i] ? 0 : wait_cnt[i] + 1;
        chk("starve", 32'(wait_cnt[i] < NCH), 32'd1);
      end else begin
        wait_cnt[i] = 0;
      end
    end
    nxt = 0;
    if (g >= 0) begin
      m_ov = 1;
      m_ch = g;
      m_y  = det_y(m_ctx[g], c[g]);
      nxt  = det_next(m_ctx[g], c[g]);
      m_last = g;
    end else begin
      m_ov = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (cl[i]) m_ctx[i] = 0;
      else if (i == g) m_ctx[i] = nxt;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    chk("out_y", 32'(out_y), 32'(m_y));
    chk("ctx", 32'(dbg_ctx), 32'(exp_dbg()));
  endtask

  // Asserts reset between edges with an optional sample in flight, then releases away from the edge.
  task automatic apply_reset(input logic [NCH-1:0] r, input logic [NCH-1:0] c);
    req = r; c_in = c; ctx_clr = '0;
    #2;
    rst_n = 1'b0;
    #1;
    req = '0;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_ctx", 32'(dbg_ctx), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] c_seq;
    logic [4:0] y_seq;
    logic [NCH-1:0] r_rand, c_rand, cl_rand;

    rst_n = 1'b0; req = '0; c_in = '0; ctx_clr = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state holds for 3 idle cycles
    for (int k = 0; k < 3; k++) begin
      do_cycle('0, '0, '0);
      chk("idle_gnt", 32'(gnt), 32'd0);
    end

    // Single channel: c = 1,0,0,1,0 gives y = 0,0,1,1,0
    c_seq = 5'b01001;
    y_seq = 5'b01100;
    for (int k = 0; k < 5; k++) begin
      do_cycle(4'b0001, {3'b000, c_seq[k]}, '0);
      chk("single_y", 32'(out_y), 32'(y_seq[k]));
      chk("single_ch", 32'(out_ch), 32'd0);
    end
    chk("single_end_ctx", 32'(dbg_ctx[1:0]), 32'd0);

    // Fairness: all requesting
    apply_reset('0, '0);
    for (int k = 0; k < 8; k++) begin
      do_cycle(4'b1111, 4'($urandom_range(0, 15)), '0);
      chk("fair_ch", 32'(out_ch), 32'(k % 4));
    end

    // Sparse requests then only channel 1
    apply_reset('0, '0);
    for (int k = 0; k < 4; k++) begin
      do_cycle(4'b1010, 4'($urandom_range(0, 15)), '0);
      chk("sparse_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle(4'b0010, 4'($urandom_range(0, 15)), '0);
      chk("sparse_one_ch", 32'(out_ch), 32'd1);
    end

    // Clear collides with a grant on channel 2
    apply_reset('0, '0);
    do_cycle(4'b0100, 4'b0100, '0);
    do_cycle(4'b0100, 4'b0000, '0);
    do_cycle(4'b0100, 4'b0100, 4'b0100);
    chk("clr_y_from_s2", 32'(out_y), 32'd1);
    do_cycle(4'b0100, 4'b0000, '0);
    chk("clr_y_after", 32'(out_y), 32'd0);

    // Async reset with a sample in flight on channel 1 sitting in S2
    apply_reset('0, '0);
    do_cycle(4'b0010, 4'b0010, '0);
    do_cycle(4'b0010, 4'b0000, '0);
    apply_reset(4'b0010, 4'b0010);
    do_cycle(4'b0010, 4'b0000, '0);
    chk("rst_mid_y", 32'(out_y), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r_rand  = 4'($urandom_range(0, 15));
      c_rand  = 4'($urandom_range(0, 15));
      cl_rand = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      do_cycle(r_rand, c_rand, cl_rand);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ctx_sched.md
# seq_ctx_sched

Time-multiplexed scheduler that shares one 2-bit sequence-detection engine among NCH input channels. A round-robin arbiter grants at most one requesting channel per cycle. It restores that channel's saved detector state from a context register file, runs one detector step on the channel's input bit, and writes the state back. The block sits between the clock-detect input lanes and downstream status logic, so one engine serves all lanes.

## Interface
- NCH, 4, number of channels (≥2)
- CW, $clog2(NCH), channel index width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  NCH  per-channel request; held high while the sample is pending
- c_in  in  NCH  per-channel sample bit; sampled only when that channel is granted
- ctx_clr  in  NCH  per-channel synchronous context clear
- gnt  out  NCH  one-hot grant, combinational from req and the rotation pointer
- out_valid  out  1  registered; high for one cycle per processed sample
- out_ch  out  CW  registered channel index of the processed sample
- out_y  out  1  registered detector output for the processed sample

## Operation
- Context file: NCH × 2-bit state registers, encoded S0=00, S1=01, S2=11, S3=10.
- Detector step for the granted channel i, with current state s and input C=c_in[i]:
  - S0: C=0 → S0; C=1 → S1.
  - S1: C=0 → S2; C=1 → S1.
  - S2: C=0 → S2; C=1 → S3.
  - S3: C=0 → S0; C=1 → S3.
- Detector output Y = (s==S2) | (s==S3 & C). Y is computed from the pre-update state.
- Arbitration: round-robin.
  - Pointer `last` holds the index of the most recently granted channel.
  - The search order is last+1, last+2, … modulo NCH. The first channel with req high is granted.
  - `last` updates only on cycles with a grant.
- gnt is all-zero when req is all-zero. gnt[i] is never high unless req[i] is high.
- A requester deasserts req[i] in the cycle after it sees gnt[i], or keeps it high to present its next sample.
- Ungranted channels' contexts hold their value.
- ctx_clr[i] forces context i to S0 at the next edge.
  - If ctx_clr[i] coincides with a grant to i, the clear wins for the context write.
  - The output for that sample is still produced, using the pre-clear state.
- ctx_clr does not affect arbitration.

## Timing
- Reset (async assert, sync use after release):
  - All contexts = S0.
  - last = NCH-1, so channel 0 has first priority.
  - out_valid = 0, out_ch = 0, out_y = 0.
- Grant and context read happen in the same cycle T. The context write-back and the out_valid/out_ch/out_y update occur at the edge ending T, so outputs are visible in cycle T+1.
- Latency from granted sample to result: 1 cycle.
- Throughput: 1 sample per cycle across all channels.
- out_valid is low in any cycle following a no-grant cycle. out_ch and out_y hold their previous values when out_valid=0.
- Starvation bound: a channel holding req high is granted within NCH cycles.
- Back-to-back grants to the same channel: each grant reads the context written by the previous edge. No hazard arises, because the write completes before the next read.
- Reset asserted mid-stream:
  - All state clears immediately, and gnt goes to 0 combinationally from req only after release.
  - A sample in flight is lost, and out_valid is 0 during reset.

## Test plan
- Reset check → with req=0 after release, gnt=0, out_valid=0, out_ch=0, out_y=0, and all contexts S0 for 3 cycles.
- Single channel: req[0] held high, c_in[0] = 1,0,0,1,0 on consecutive cycles → out_valid=1 on 5 consecutive cycles with out_ch=0, out_y = 0,0,1,1,0; context ends S0.
- Fairness, NCH=4: req=4'b1111 for 8 cycles → gnt = 0001,0010,0100,1000,0001,0010,0100,1000.
- Sparse requests: req=4'b1010 after reset → gnt alternates 0010,1000. Then drop req[3] → gnt stays 0010 every cycle.
- Clear collision:
  - Drive channel 2 to S2 via c_in=1,0.
  - Next grant with C=1 and ctx_clr[2]=1 → out_y=1 (from S2).
  - The following grant with C=0 → out_y=0, confirming the context is S0.
- Async reset mid-stream: drive channel 1 into S2, assert rst_n low between edges → outputs drop to 0 immediately. After release, the first grant to channel 1 with C=0 gives out_y=0 (context S0).
